// File: rtl/case_1_accum_pkg.sv
// case_1_accum_pkg: shared FSM state type and default widths for the product accumulator
package case_1_accum_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
    localparam int DIN_WIDTH = 7;
    localparam int ACC_WIDTH = 16;
    localparam int CNT_WIDTH = 8;
endpackage

// File: rtl/case_1_add_ovf_chk.sv
// case_1_add_ovf_chk: sign-extending wrapping adder with signed-overflow detect
module case_1_add_ovf_chk #(
    parameter int DIN_WIDTH = 7,
    parameter int ACC_WIDTH = 16
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [DIN_WIDTH-1:0] din,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 ovf
);
    logic [ACC_WIDTH-1:0] din_ext;
    always_comb begin
        din_ext = {{(ACC_WIDTH-DIN_WIDTH){din[DIN_WIDTH-1]}}, din};
        sum     = acc + din_ext;
        ovf     = (acc[ACC_WIDTH-1] == din_ext[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    end
endmodule

// File: rtl/case_1_prod_accum_7s.sv
// case_1_prod_accum_7s: sums len_cfg signed products under an ap_start/ap_done block protocol
module case_1_prod_accum_7s
    import case_1_accum_pkg::*;
#(
    parameter int DIN_WIDTH = case_1_accum_pkg::DIN_WIDTH,
    parameter int ACC_WIDTH = case_1_accum_pkg::ACC_WIDTH,
    parameter int CNT_WIDTH = case_1_accum_pkg::CNT_WIDTH
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_start,
    output logic                 ap_idle,
    output logic                 ap_ready,
    output logic                 ap_done,
    input  logic [CNT_WIDTH-1:0] len_cfg,
    input  logic [DIN_WIDTH-1:0] prod_din,
    input  logic                 prod_vld,
    output logic                 prod_rdy,
    output logic [ACC_WIDTH-1:0] acc_dout,
    output logic                 acc_ovf,
    output logic                 acc_vld,
    input  logic                 acc_rdy
);
    state_t               state;
    logic [CNT_WIDTH-1:0] len;
    logic [CNT_WIDTH-1:0] cnt;
    logic [ACC_WIDTH-1:0] sum;
    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_ovf;
    logic                 ovf;

    case_1_add_ovf_chk #(.DIN_WIDTH(DIN_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_add (
        .acc(sum),
        .din(prod_din),
        .sum(add_sum),
        .ovf(add_ovf)
    );

    always_comb begin
        ap_idle  = state == IDLE;
        prod_rdy = state == ACCUM;
        acc_vld  = state == OUTPUT;
        ap_ready = ap_idle && ap_start;
        ap_done  = acc_vld && acc_rdy;
        acc_dout = sum;
        acc_ovf  = ovf;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
            len   <= '0;
            cnt   <= '0;
            sum   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ap_start) begin
                    len   <= len_cfg;
                    cnt   <= '0;
                    sum   <= '0;
                    ovf   <= 1'b0;
                    state <= (len_cfg != '0) ? ACCUM : OUTPUT;
                end
                ACCUM: if (prod_vld) begin
                    sum   <= add_sum;
                    ovf   <= ovf | add_ovf;
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == len - 1'b1) ? OUTPUT : ACCUM;
                end
                OUTPUT: if (acc_rdy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_case_1_prod_accum_7s.sv
// tb_case_1_prod_accum_7s: directed table-driven bench for the product accumulator
module tb_case_1_prod_accum_7s;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n, ap_start, prod_vld, acc_rdy;
    logic [7:0]  len_cfg;
    logic [6:0]  prod_din;
    logic        ap_idle, ap_ready, ap_done, prod_rdy, acc_ovf, acc_vld;
    logic [15:0] acc_dout;
    logic        n_idle, n_ready, n_done, n_prdy, n_ovf, n_vld;
    logic [11:0] n_dout;
    logic [21:0] obs;
    int          total = 0;
    int          bad = 0;
    int          beats;
    int          done_cnt = 0;
    int          d0;

    typedef struct {
        logic       st;
        logic [7:0] len;
        logic [6:0] din;
        logic       vld;
        logic       rdy;
        logic [21:0] exp;
    } vec_t;
    vec_t vecs[18];

    always #5 ap_clk = ~ap_clk;

    case_1_prod_accum_7s dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_idle(ap_idle),
        .ap_ready(ap_ready), .ap_done(ap_done), .len_cfg(len_cfg), .prod_din(prod_din),
        .prod_vld(prod_vld), .prod_rdy(prod_rdy), .acc_dout(acc_dout), .acc_ovf(acc_ovf),
        .acc_vld(acc_vld), .acc_rdy(acc_rdy)
    );

    case_1_prod_accum_7s #(.ACC_WIDTH(12)) dut_n (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_idle(n_idle),
        .ap_ready(n_ready), .ap_done(n_done), .len_cfg(len_cfg), .prod_din(prod_din),
        .prod_vld(prod_vld), .prod_rdy(n_prdy), .acc_dout(n_dout), .acc_ovf(n_ovf),
        .acc_vld(n_vld), .acc_rdy(acc_rdy)
    );

    assign obs = {ap_idle, ap_ready, ap_done, prod_rdy, acc_vld, acc_ovf, acc_dout};

    always @(posedge ap_clk) if (ap_done) done_cnt <= done_cnt + 1;

    function automatic logic [21:0] e(input logic idle, input logic rdy, input logic dn,
                                      input logic prdy, input logic avld, input logic ov,
                                      input logic [15:0] dout);
        return {idle, rdy, dn, prdy, avld, ov, dout};
    endfunction

    function automatic vec_t v(input logic st, input logic [7:0] len, input logic [6:0] din,
                               input logic vld, input logic rdy, input logic [21:0] exp);
        vec_t r;
        r.st = st; r.len = len; r.din = din; r.vld = vld; r.rdy = rdy; r.exp = exp;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        // len=4 run (len_cfg changed mid-run), len=0 run, back-to-back len=1 runs
        vecs[0]  = v(1, 8'd4, 7'h00, 0, 0, e(1,1,0,0,0,0,16'd0));
        vecs[1]  = v(0, 8'd4, 7'h03, 1, 0, e(0,0,0,1,0,0,16'd0));
        vecs[2]  = v(0, 8'd9, 7'h7B, 1, 0, e(0,0,0,1,0,0,16'd3));
        vecs[3]  = v(0, 8'd9, 7'h07, 1, 0, e(0,0,0,1,0,0,16'hFFFE));
        vecs[4]  = v(0, 8'd9, 7'h7F, 1, 0, e(0,0,0,1,0,0,16'd5));
        vecs[5]  = v(0, 8'd4, 7'h00, 0, 1, e(0,0,1,0,1,0,16'd4));
        vecs[6]  = v(0, 8'd4, 7'h00, 0, 0, e(1,0,0,0,0,0,16'd4));
        vecs[7]  = v(1, 8'd0, 7'h00, 0, 0, e(1,1,0,0,0,0,16'd4));
        vecs[8]  = v(0, 8'd0, 7'h00, 0, 0, e(0,0,0,0,1,0,16'd0));
        vecs[9]  = v(0, 8'd0, 7'h00, 0, 1, e(0,0,1,0,1,0,16'd0));
        vecs[10] = v(0, 8'd0, 7'h00, 0, 0, e(1,0,0,0,0,0,16'd0));
        vecs[11] = v(1, 8'd1, 7'h00, 0, 0, e(1,1,0,0,0,0,16'd0));
        vecs[12] = v(1, 8'd1, 7'h0A, 1, 0, e(0,0,0,1,0,0,16'd0));
        vecs[13] = v(1, 8'd1, 7'h00, 0, 1, e(0,0,1,0,1,0,16'd10));
        vecs[14] = v(1, 8'd1, 7'h00, 0, 1, e(1,1,0,0,0,0,16'd10));
        vecs[15] = v(1, 8'd1, 7'h14, 1, 1, e(0,0,0,1,0,0,16'd0));
        vecs[16] = v(0, 8'd1, 7'h00, 0, 1, e(0,0,1,0,1,0,16'd20));
        vecs[17] = v(0, 8'd1, 7'h00, 0, 0, e(1,0,0,0,0,0,16'd20));

        ap_rst_n = 1'b0; ap_start = 1'b0; len_cfg = '0; prod_din = '0; prod_vld = 1'b0; acc_rdy = 1'b0;
        #3;
        chk("reset_outputs", 32'(obs), 32'(e(1,0,0,0,0,0,16'd0)));
        tick; tick;
        ap_rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            ap_start = vecs[i].st; len_cfg = vecs[i].len; prod_din = vecs[i].din;
            prod_vld = vecs[i].vld; acc_rdy = vecs[i].rdy;
            #2;
            chk($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
            tick;
        end
        ap_start = 1'b0; prod_vld = 1'b0; acc_rdy = 1'b0;

        // stalled input and stalled output
        ap_start = 1'b1; len_cfg = 8'd3;
        #2 chk("stall_ready", 32'(ap_ready), 32'd1);
        tick;
        ap_start = 1'b0;
        beats = 0;
        for (int i = 0; i < 6; i++) begin
            prod_vld = (i == 0 || i == 3 || i == 5);
            prod_din = (i == 0) ? 7'h05 : (i == 3) ? 7'h79 : (i == 5) ? 7'h14 : 7'h40;
            #2;
            chk($sformatf("stall_prdy%0d", i), 32'(prod_rdy), 32'd1);
            if (prod_vld && prod_rdy) beats++;
            tick;
        end
        prod_vld = 1'b0;
        chk("stall_beats", 32'(beats), 32'd3);
        for (int i = 0; i < 5; i++) begin
            #2;
            chk($sformatf("stall_hold%0d", i), 32'(obs), 32'(e(0,0,0,0,1,0,16'd18)));
            tick;
        end
        acc_rdy = 1'b1;
        #2 chk("stall_done", 32'(obs), 32'(e(0,0,1,0,1,0,16'd18)));
        tick;
        acc_rdy = 1'b0;
        #2 chk("stall_idle", 32'(ap_idle), 32'd1);
        tick;

        // 255 x 63: fits in 16 bits, overflows and wraps in 12 bits
        ap_start = 1'b1; len_cfg = 8'd255;
        tick;
        ap_start = 1'b0; prod_vld = 1'b1; prod_din = 7'h3F;
        beats = 0;
        for (int i = 0; i < 300; i++) begin
            #2;
            if (acc_vld) break;
            if (prod_rdy) beats++;
            tick;
        end
        prod_vld = 1'b0;
        chk("long_vld", 32'(acc_vld), 32'd1);
        chk("long_beats", 32'(beats), 32'd255);
        chk("long_sum16", 32'({acc_ovf, acc_dout}), 32'({1'b0, 16'd16065}));
        chk("long_sum12", 32'({n_vld, n_ovf, n_dout}), 32'({1'b1, 1'b1, 12'hEC1}));
        acc_rdy = 1'b1;
        tick;
        acc_rdy = 1'b0;

        // reset mid-run after 2 of 5 beats, then a fresh run
        d0 = done_cnt;
        ap_start = 1'b1; len_cfg = 8'd5;
        tick;
        ap_start = 1'b0; prod_vld = 1'b1; prod_din = 7'h1E;
        tick; tick;
        prod_vld = 1'b0;
        #2 chk("pre_reset_sum", 32'(obs), 32'(e(0,0,0,1,0,0,16'd60)));
        ap_rst_n = 1'b0;
        #1 chk("mid_reset", 32'(obs), 32'(e(1,0,0,0,0,0,16'd0)));
        @(posedge ap_clk);
        #3 ap_rst_n = 1'b1;
        chk("reset_no_done", 32'(done_cnt), 32'(d0));
        tick;
        ap_start = 1'b1; len_cfg = 8'd2;
        #2 chk("fresh_ready", 32'(ap_ready), 32'd1);
        tick;
        ap_start = 1'b0; prod_vld = 1'b1; prod_din = 7'h01;
        tick; tick;
        prod_vld = 1'b0; acc_rdy = 1'b1;
        #2 chk("fresh_result", 32'(obs), 32'(e(0,0,1,0,1,0,16'd2)));
        tick;
        acc_rdy = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
